int_dot_accum_feeder: RTL and testbench

- Upstream feeder for the 7-cycle fp32 converter, `int_to_float`.
- Accumulates a framed stream of signed DATA_W x DATA_W products into an ACC_W accumulator.
- At end of frame, saturates the sum to signed 32 bits and holds it on `acc_out`, which drives the converter's `input_a`.
- Also produces `fp_valid`, a valid strobe delayed to line up with the converter's `output_z`, because the converter itself carries no valid signal.

---
 rtl/int_accum_pkg.sv | 41 ++++
 rtl/valid_delay_line.sv | 28 ++
 rtl/int_dot_accum_feeder.sv | 171 +++++++++++++++++
 tb/tb_int_dot_accum_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_accum_pkg.sv
// Shared types, constants and the 32-bit saturation helper for the integer
// dot-product accumulator that feeds the int_to_float converter.
package int_accum_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ACC_W    = 40;
  localparam int DEF_CONV_LAT = 7;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  localparam logic signed [63:0] SAT_HI = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_LO = 64'shFFFF_FFFF_8000_0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] val;
    logic        sat;
  } sat_res_t;

  // Clamp a sign-extended sum to the int32 range and report whether it clipped.
  function automatic sat_res_t sat_to_32(input logic signed [63:0] v);
    sat_res_t r;
    if (v > SAT_HI) begin
      r.val = INT32_MAX;
      r.sat = 1'b1;
    end else if (v < SAT_LO) begin
      r.val = INT32_MIN;
      r.sat = 1'b1;
    end else begin
      r.val = v[31:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency shift register for valid strobes; lines a strobe up with the
// output of a pipelined unit that carries no valid of its own.
module valid_delay_line #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_r;

  // Shift the strobe one stage per cycle; reset flushes anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r <= '0;
    end else begin
      sr_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/int_dot_accum_feeder.sv
// Framed signed multiply-accumulate; emits a saturated int32 frame sum for the
// int_to_float converter plus a valid strobe aligned with the converter output.
module int_dot_accum_feeder
  import int_accum_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CONV_LAT = DEF_CONV_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [31:0]       acc_out,
  output logic              acc_valid,
  output logic              fp_valid,
  output logic              sat_flag,
  output logic              err_flag
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0]        a_r, b_r;
  logic                     v1_r, f1_r, l1_r;
  logic signed [PROD_W-1:0] a_ext_s, b_ext_s;
  logic signed [PROD_W-1:0] prod_r;
  logic                     v2_r, f2_r, l2_r;
  logic signed [ACC_W-1:0]  prod_ext_s, acc_r, acc_next_s;
  logic signed [ACC_W-1:0]  emit_sum_s, emit_sum_r;
  logic signed [63:0]       emit_wide_s;
  state_e                   state_r, state_next_s;
  logic                     emit_s, emit_r, err_set_s;
  sat_res_t                 sat_s;

  // Stage 1: register operands together with their frame flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      b_r  <= '0;
      v1_r <= 1'b0;
      f1_r <= 1'b0;
      l1_r <= 1'b0;
    end else begin
      a_r  <= in_a;
      b_r  <= in_b;
      v1_r <= in_valid;
      f1_r <= in_first;
      l1_r <= in_last;
    end
  end

  // Operands are widened to the product width so the low half is the exact product.
  assign a_ext_s = {{DATA_W{a_r[DATA_W-1]}}, a_r};
  assign b_ext_s = {{DATA_W{b_r[DATA_W-1]}}, b_r};

  // Stage 2: register the signed product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r <= '0;
      v2_r   <= 1'b0;
      f2_r   <= 1'b0;
      l2_r   <= 1'b0;
    end else begin
      prod_r <= a_ext_s * b_ext_s;
      v2_r   <= v1_r;
      f2_r   <= f1_r;
      l2_r   <= l1_r;
    end
  end

  assign prod_ext_s = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};

  // Frame state machine: decides accumulate, restart, emit or drop for each beat.
  always_comb begin
    acc_next_s   = acc_r;
    state_next_s = state_r;
    emit_s       = 1'b0;
    emit_sum_s   = acc_r;
    err_set_s    = 1'b0;
    if (v2_r) begin
      case (state_r)
        IDLE: begin
          if (f2_r) begin
            acc_next_s = prod_ext_s;
            emit_sum_s = prod_ext_s;
            if (l2_r) begin
              emit_s = 1'b1;
            end else begin
              state_next_s = ACCUM;
            end
          end else begin
            err_set_s = 1'b1;
          end
        end
        ACCUM: begin
          if (f2_r) begin
            // A first beat mid-frame abandons the partial sum.
            err_set_s  = 1'b1;
            acc_next_s = prod_ext_s;
            emit_sum_s = prod_ext_s;
          end else begin
            acc_next_s = acc_r + prod_ext_s;
            emit_sum_s = acc_r + prod_ext_s;
          end
          if (l2_r) begin
            emit_s       = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = ACCUM;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Stage 3: accumulator, state, pending emit and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r      <= '0;
      state_r    <= IDLE;
      emit_r     <= 1'b0;
      emit_sum_r <= '0;
      err_flag   <= 1'b0;
    end else begin
      acc_r      <= acc_next_s;
      state_r    <= state_next_s;
      emit_r     <= emit_s;
      emit_sum_r <= emit_sum_s;
      err_flag   <= err_flag | err_set_s;
    end
  end

  assign emit_wide_s = {{(64-ACC_W){emit_sum_r[ACC_W-1]}}, emit_sum_r};
  assign sat_s       = sat_to_32(emit_wide_s);

  // Stage 4: saturated result holds on acc_out until the next emit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_out   <= '0;
      sat_flag  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= emit_r;
      if (emit_r) begin
        acc_out  <= sat_s.val;
        sat_flag <= sat_s.sat;
      end else begin
        acc_out  <= acc_out;
        sat_flag <= sat_flag;
      end
    end
  end

  valid_delay_line #(
    .DEPTH (CONV_LAT)
  ) u_fp_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (acc_valid),
    .dout (fp_valid)
  );

endmodule

// File: tb/tb_int_dot_accum_feeder.sv
// Directed bench for int_dot_accum_feeder: framing, latency, saturation,
// restart/error handling and asynchronous reset mid-frame.
module tb_int_dot_accum_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_first, in_last;
  logic [15:0] in_a, in_b;
  logic [31:0] acc_out;
  logic        acc_valid, fp_valid, sat_flag, err_flag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_fp     = 0;

  int_dot_accum_feeder #(
    .DATA_W   (16),
    .ACC_W    (40),
    .CONV_LAT (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .fp_valid  (fp_valid),
    .sat_flag  (sat_flag),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_valid === 1'b1) n_acc++;
    if (fp_valid === 1'b1) n_fp++;
  end

  task automatic beat(input logic f, input logic l, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int budget, output int at, output bit seen);
    int i;
    seen = 1'b0;
    at   = -1;
    i    = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (acc_valid === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
      i++;
    end
  endtask

  task automatic wait_fp(input int budget, output int at, output bit seen);
    int i;
    seen = 1'b0;
    at   = -1;
    i    = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (fp_valid === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
      i++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_a = 16'h0; in_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (acc_out !== 32'h0) begin failures++; $display("FAIL reset_acc_out: got %h expected %h", acc_out, 32'h0); end
    checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL reset_acc_valid: got %b expected 0", acc_valid); end
    checks++; if (fp_valid !== 1'b0) begin failures++; $display("FAIL reset_fp_valid: got %b expected 0", fp_valid); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
    checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame;
    int e, at, n0;
    bit seen;
    n0 = n_acc;
    beat(1'b1, 1'b0, 16'd3, 16'd4);
    beat(1'b0, 1'b0, 16'hFFFE, 16'd5);
    beat(1'b0, 1'b1, 16'd7, 16'd7);
    e = cyc;
    wait_acc(10, at, seen);
    checks++; if (!seen || at !== e + 3) begin failures++; $display("FAIL basic_acc_latency: got cycle %0d (seen=%0b) expected %0d", at, seen, e + 3); end
    checks++; if (acc_out !== 32'h0000_0033) begin failures++; $display("FAIL basic_acc_out: got %h expected %h", acc_out, 32'h33); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL basic_sat_flag: got %b expected 0", sat_flag); end
    wait_fp(12, at, seen);
    checks++; if (!seen || at !== e + 10) begin failures++; $display("FAIL basic_fp_latency: got cycle %0d (seen=%0b) expected %0d", at, seen, e + 10); end
    @(negedge clk);
    checks++; if (fp_valid !== 1'b0) begin failures++; $display("FAIL basic_fp_width: got %b expected 0", fp_valid); end
    idle(2);
    checks++; if (n_acc - n0 !== 1) begin failures++; $display("FAIL basic_acc_pulses: got %0d expected 1", n_acc - n0); end
  endtask

  task automatic test_back_to_back;
    int e, at;
    bit seen;
    beat(1'b1, 1'b1, 16'hFFFF, 16'd1);
    beat(1'b1, 1'b1, 16'd2, 16'd3);
    e = cyc;
    wait_acc(10, at, seen);
    checks++; if (!seen || at !== e + 2 || acc_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_first: got %h at %0d expected %h at %0d", acc_out, at, 32'hFFFF_FFFF, e + 2); end
    @(negedge clk);
    checks++; if (acc_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid: got %b expected 1", acc_valid); end
    checks++; if (acc_out !== 32'h0000_0006) begin failures++; $display("FAIL b2b_second_value: got %h expected %h", acc_out, 32'h6); end
    idle(12);
  endtask

  task automatic test_sat_pos;
    int at;
    bit seen;
    beat(1'b1, 1'b0, 16'h8000, 16'h8000);
    beat(1'b0, 1'b0, 16'h8000, 16'h8000);
    beat(1'b0, 1'b1, 16'h8000, 16'h8000);
    wait_acc(10, at, seen);
    checks++; if (!seen || acc_out !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_pos_value: got %h (seen=%0b) expected %h", acc_out, seen, 32'h7FFF_FFFF); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_pos_flag: got %b expected 1", sat_flag); end
    idle(12);
  endtask

  task automatic test_sat_neg;
    int at;
    bit seen;
    beat(1'b1, 1'b0, 16'h8000, 16'h7FFF);
    beat(1'b0, 1'b0, 16'h8000, 16'h7FFF);
    beat(1'b0, 1'b1, 16'h8000, 16'h7FFF);
    wait_acc(10, at, seen);
    checks++; if (!seen || acc_out !== 32'h8000_0000) begin failures++; $display("FAIL sat_neg_value: got %h (seen=%0b) expected %h", acc_out, seen, 32'h8000_0000); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_neg_flag: got %b expected 1", sat_flag); end
    idle(12);
  endtask

  task automatic test_restart;
    int at, n0;
    bit seen;
    checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL restart_err_before: got %b expected 0", err_flag); end
    n0 = n_acc;
    beat(1'b1, 1'b0, 16'd5, 16'd5);
    beat(1'b0, 1'b0, 16'd1, 16'd1);
    beat(1'b1, 1'b1, 16'd2, 16'd2);
    wait_acc(10, at, seen);
    checks++; if (!seen || acc_out !== 32'h0000_0004) begin failures++; $display("FAIL restart_value: got %h (seen=%0b) expected %h", acc_out, seen, 32'h4); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL restart_sat_flag: got %b expected 0", sat_flag); end
    checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL restart_err_flag: got %b expected 1", err_flag); end
    idle(12);
    checks++; if (n_acc - n0 !== 1) begin failures++; $display("FAIL restart_pulses: got %0d expected 1", n_acc - n0); end
  endtask

  task automatic test_reset_midflight;
    int at, n0, f0;
    bit seen;
    beat(1'b1, 1'b1, 16'd3, 16'd3);
    wait_acc(10, at, seen);
    checks++; if (!seen || acc_out !== 32'h0000_0009) begin failures++; $display("FAIL midrst_prior_value: got %h (seen=%0b) expected %h", acc_out, seen, 32'h9); end
    idle(2);
    beat(1'b1, 1'b0, 16'd1, 16'd1);
    beat(1'b0, 1'b0, 16'd1, 16'd1);
    in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0; in_a = 16'd1; in_b = 16'd1;
    rst = 1'b0;
    #1;
    checks++; if (acc_out !== 32'h0) begin failures++; $display("FAIL midrst_acc_out: got %h expected %h", acc_out, 32'h0); end
    checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL midrst_acc_valid: got %b expected 0", acc_valid); end
    checks++; if (fp_valid !== 1'b0) begin failures++; $display("FAIL midrst_fp_valid: got %b expected 0", fp_valid); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL midrst_sat_flag: got %b expected 0", sat_flag); end
    checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL midrst_err_flag: got %b expected 0", err_flag); end
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    n0 = n_acc;
    f0 = n_fp;
    idle(20);
    checks++; if (n_acc !== n0) begin failures++; $display("FAIL midrst_no_acc_valid: got %0d pulses expected 0", n_acc - n0); end
    checks++; if (n_fp !== f0) begin failures++; $display("FAIL midrst_no_fp_valid: got %0d pulses expected 0", n_fp - f0); end
    checks++; if (acc_out !== 32'h0) begin failures++; $display("FAIL midrst_acc_out_held: got %h expected %h", acc_out, 32'h0); end
    beat(1'b1, 1'b1, 16'd1, 16'd1);
    wait_acc(10, at, seen);
    checks++; if (!seen || acc_out !== 32'h0000_0001) begin failures++; $display("FAIL midrst_clean_frame: got %h (seen=%0b) expected %h", acc_out, seen, 32'h1); end
    checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL midrst_clean_err: got %b expected 0", err_flag); end
    idle(12);
  endtask

  task automatic test_stray_beat;
    int n0;
    n0 = n_acc;
    beat(1'b0, 1'b0, 16'd9, 16'd9);
    idle(8);
    checks++; if (n_acc !== n0) begin failures++; $display("FAIL stray_no_emit: got %0d pulses expected 0", n_acc - n0); end
    checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL stray_err_flag: got %b expected 1", err_flag); end
    checks++; if (acc_out !== 32'h0000_0001) begin failures++; $display("FAIL stray_acc_out_held: got %h expected %h", acc_out, 32'h1); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_back_to_back;
    test_sat_pos;
    test_sat_neg;
    test_restart;
    test_reset_midflight;
    test_stray_beat;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
